// File: rtl/sync_pattern_gen_pkg.sv
// rtl/sync_pattern_gen_pkg.sv - shared encodings for the sync/sample-clock/data pattern generator
//
// Purpose : data pattern mode encodings, control state encodings and the
//           PRBS seed, shared by sync_pattern_gen and its LFSR sub-module.
// Ports   : none (package).
// Macro   : SYNC_PATTERN_GEN_PRBS_EN enables the PRBS seed constant.

package sync_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_PRBS   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

`ifdef SYNC_PATTERN_GEN_PRBS_EN
  // Base seed; each channel XORs its index in so channels are decorrelated.
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;
`endif

endpackage

// File: rtl/sync_pattern_gen_prbs15_lfsr.sv
// rtl/sync_pattern_gen_prbs15_lfsr.sv - PRBS-15 (x^15+x^14+1) LFSR, one bit per step
//
// Purpose : Fibonacci PRBS-15 generator with synchronous seed load and step enable.
// Ports   : i_clk    clock, rising edge
//           i_rst_n  asynchronous active-low reset
//           i_load   load i_seed (has priority over i_step)
//           i_seed   15-bit seed
//           i_step   advance one position
//           o_bit    current sequence bit (register MSB)
// Macro   : only compiled when SYNC_PATTERN_GEN_PRBS_EN is defined.

`ifdef SYNC_PATTERN_GEN_PRBS_EN
module sync_pattern_gen_prbs15_lfsr (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [14:0] i_seed,
  input  logic        i_step,
  output logic        o_bit
);

  logic [14:0] r_lfsr;
  logic        w_fb;

  // Taps at stages 15 and 14 give the maximal-length 32767 sequence.
  assign w_fb  = r_lfsr[14] ^ r_lfsr[13];
  assign o_bit = r_lfsr[14];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // Non-zero so the register can never sit in the all-zero lock state.
      r_lfsr <= 15'h7FFF;
    end else if (i_load) begin
      r_lfsr <= i_seed;
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[13:0], w_fb};
    end
  end

endmodule
`endif

// File: rtl/sync_pattern_gen.sv
// rtl/sync_pattern_gen.sv - start/stop controlled frame-sync, sample-clock and test-data generator
//
// Purpose : generates SYNC / SPCLK / DATA for ADC acquisition bring-up from a
//           shadowed runtime configuration; shadow is captured on leaving IDLE
//           and again at every frame boundary while running.
// Ports   : mclk        clock, rising edge
//           rst_n       asynchronous active-low reset
//           en          run request (level)
//           div_max     sample period minus 1 (0 behaves as 1)
//           spclk_high  out_spclk high while div < spclk_high
//           frame_len   samples per frame minus 1
//           sync_len    out_sync high while sample < sync_len
//           data_split  LEVEL mode threshold
//           mode        0 LEVEL, 1 TOGGLE, 2 COUNT, 3 PRBS
//           out_sync, out_spclk, out_data[NCHN]  pattern outputs
//           sample_stb  pulse after the last div cycle of a sample
//           frame_stb   pulse after the last cycle of a frame
//           frame_cnt   completed frames since leaving IDLE
//           busy        high while RUN or STOP
// Macro   : SYNC_PATTERN_GEN_PRBS_EN adds per-channel PRBS-15 data in mode 3;
//           without it mode 3 drives constant 0.

module sync_pattern_gen
  import sync_pattern_gen_pkg::*;
#(
  parameter int DIV_NBIT   = 9,
  parameter int FRAME_NBIT = 10,
  parameter int NCHN       = 1,
  parameter int FCNT_NBIT  = 16
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_NBIT-1:0]   div_max,
  input  logic [DIV_NBIT-1:0]   spclk_high,
  input  logic [FRAME_NBIT-1:0] frame_len,
  input  logic [FRAME_NBIT-1:0] sync_len,
  input  logic [FRAME_NBIT-1:0] data_split,
  input  logic [1:0]            mode,
  output logic                  out_sync,
  output logic                  out_spclk,
  output logic [NCHN-1:0]       out_data,
  output logic                  sample_stb,
  output logic                  frame_stb,
  output logic [FCNT_NBIT-1:0]  frame_cnt,
  output logic                  busy
);

  state_t                r_state;
  logic [DIV_NBIT-1:0]   r_div;
  logic [FRAME_NBIT-1:0] r_sample;
  logic [FCNT_NBIT-1:0]  r_frame_cnt;

  // Shadow configuration
  logic [DIV_NBIT-1:0]   r_div_max;
  logic [DIV_NBIT-1:0]   r_spclk_high;
  logic [FRAME_NBIT-1:0] r_frame_len;
  logic [FRAME_NBIT-1:0] r_sync_len;
  logic [FRAME_NBIT-1:0] r_data_split;
  mode_t                 r_mode;

  // Registered outputs
  logic                  r_sync;
  logic                  r_spclk;
  logic [NCHN-1:0]       r_data;
  logic                  r_sample_stb;
  logic                  r_frame_stb;
  logic                  r_busy;

  logic [DIV_NBIT-1:0]   w_div_max_eff;
  logic                  w_active;
  logic                  w_div_end;
  logic                  w_frame_end;
  logic                  w_start;
  logic                  w_load;
  logic [NCHN-1:0]       w_data;
  logic [NCHN-1:0]       w_prbs;

  // A one-cycle sample period is not supported; 0 is stretched to 2 cycles.
  assign w_div_max_eff = (r_div_max == '0) ? DIV_NBIT'(1) : r_div_max;
  assign w_active      = (r_state != ST_IDLE);
  assign w_div_end     = (r_div == w_div_max_eff);
  assign w_frame_end   = w_div_end && (r_sample == r_frame_len);
  assign w_start       = (r_state == ST_IDLE) && en;
  // Frame-boundary reload happens in RUN regardless of en, so the frame
  // completed in STOP still uses the configuration it started with.
  assign w_load        = w_start || ((r_state == ST_RUN) && w_frame_end);

`ifdef SYNC_PATTERN_GEN_PRBS_EN
  for (genvar k = 0; k < NCHN; k++) begin : g_prbs
    sync_pattern_gen_prbs15_lfsr u_lfsr (
      .i_clk   (mclk),
      .i_rst_n (rst_n),
      .i_load  (w_start),
      .i_seed  (PRBS_SEED ^ 15'(k)),
      .i_step  (w_active && w_div_end),
      .o_bit   (w_prbs[k])
    );
  end
`else
  assign w_prbs = '0;
`endif

  always_comb begin
    w_data = '0;
    for (int k = 0; k < NCHN; k++) begin
      case (r_mode)
        MODE_LEVEL:  w_data[k] = (r_sample < r_data_split);
        MODE_TOGGLE: w_data[k] = r_sample[0] ^ ((k % 2) != 0);
        MODE_COUNT:  w_data[k] = r_sample[k % FRAME_NBIT];
        MODE_PRBS:   w_data[k] = w_prbs[k];
        default:     w_data[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_sample     <= '0;
      r_frame_cnt  <= '0;
      r_div_max    <= '0;
      r_spclk_high <= '0;
      r_frame_len  <= '0;
      r_sync_len   <= '0;
      r_data_split <= '0;
      r_mode       <= MODE_LEVEL;
      r_sync       <= 1'b0;
      r_spclk      <= 1'b0;
      r_data       <= '0;
      r_sample_stb <= 1'b0;
      r_frame_stb  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Outputs are a registered image of the pre-edge counters, so every
      // output shares the same one-cycle latency; IDLE forces them low.
      r_busy       <= w_active;
      r_spclk      <= w_active && (r_div < r_spclk_high);
      r_sync       <= w_active && (r_sample < r_sync_len);
      r_data       <= w_active ? w_data : '0;
      r_sample_stb <= w_active && w_div_end;
      r_frame_stb  <= w_active && w_frame_end;

      if (w_active) begin
        if (w_div_end) begin
          r_div    <= '0;
          r_sample <= w_frame_end ? '0 : r_sample + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
        if (w_frame_end) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end

      if (w_load) begin
        r_div_max    <= div_max;
        r_spclk_high <= spclk_high;
        r_frame_len  <= frame_len;
        r_sync_len   <= sync_len;
        r_data_split <= data_split;
        r_mode       <= mode_t'(mode);
      end

      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_div       <= '0;
            r_sample    <= '0;
            r_frame_cnt <= '0;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) r_state <= ST_STOP;
        end
        ST_STOP: begin
          // The frame in progress always completes before returning to IDLE.
          if (w_frame_end)  r_state <= ST_IDLE;
          else if (en)      r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_sync   = r_sync;
  assign out_spclk  = r_spclk;
  assign out_data   = r_data;
  assign sample_stb = r_sample_stb;
  assign frame_stb  = r_frame_stb;
  assign frame_cnt  = r_frame_cnt;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sync_pattern_gen.sv
// tb/tb_sync_pattern_gen.sv - self-checking bench for sync_pattern_gen against a frame-position model

module tb_sync_pattern_gen;

  localparam int DIV_NBIT   = 9;
  localparam int FRAME_NBIT = 10;
  localparam int NCHN       = 2;
  localparam int FCNT_NBIT  = 16;

  logic                  mclk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic [DIV_NBIT-1:0]   div_max = '0;
  logic [DIV_NBIT-1:0]   spclk_high = '0;
  logic [FRAME_NBIT-1:0] frame_len = '0;
  logic [FRAME_NBIT-1:0] sync_len = '0;
  logic [FRAME_NBIT-1:0] data_split = '0;
  logic [1:0]            mode = 2'd0;
  logic                  out_sync;
  logic                  out_spclk;
  logic [NCHN-1:0]       out_data;
  logic                  sample_stb;
  logic                  frame_stb;
  logic [FCNT_NBIT-1:0]  frame_cnt;
  logic                  busy;

  sync_pattern_gen #(
    .DIV_NBIT   (DIV_NBIT),
    .FRAME_NBIT (FRAME_NBIT),
    .NCHN       (NCHN),
    .FCNT_NBIT  (FCNT_NBIT)
  ) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .en         (en),
    .div_max    (div_max),
    .spclk_high (spclk_high),
    .frame_len  (frame_len),
    .sync_len   (sync_len),
    .data_split (data_split),
    .mode       (mode),
    .out_sync   (out_sync),
    .out_spclk  (out_spclk),
    .out_data   (out_data),
    .sample_stb (sample_stb),
    .frame_stb  (frame_stb),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 mclk = ~mclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the generator is described by its position (in mclk
  // cycles) inside the current frame; div and sample are derived from it.
  int m_state;   // 0 idle, 1 run, 2 stop
  int m_pos;
  int m_fcnt;
  int s_dm, s_sh, s_fl, s_sl, s_ds, s_mode;
  int m_lfsr [NCHN];

  logic                 e_sync, e_spclk, e_sstb, e_fstb, e_busy;
  logic [NCHN-1:0]      e_data;
  logic [FCNT_NBIT-1:0] e_fcnt;

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_fcnt = 0;
    s_dm = 0; s_sh = 0; s_fl = 0; s_sl = 0; s_ds = 0; s_mode = 0;
    e_sync = 0; e_spclk = 0; e_sstb = 0; e_fstb = 0; e_busy = 0;
    e_data = '0; e_fcnt = '0;
  endtask

  task automatic model_load();
    s_dm = int'(div_max); s_sh = int'(spclk_high); s_fl = int'(frame_len);
    s_sl = int'(sync_len); s_ds = int'(data_split); s_mode = int'(mode);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    int  period, dv, smp;
    bit  active, div_end, frame_end;
    period    = ((s_dm == 0) ? 1 : s_dm) + 1;
    dv        = m_pos % period;
    smp       = m_pos / period;
    active    = (m_state != 0);
    div_end   = (dv == period - 1);
    frame_end = div_end && (smp == s_fl);

    e_busy  = active;
    e_spclk = active && (dv < s_sh);
    e_sync  = active && (smp < s_sl);
    e_sstb  = active && div_end;
    e_fstb  = active && frame_end;
    for (int k = 0; k < NCHN; k++) begin
      bit b;
      case (s_mode)
        0: b = (smp < s_ds);
        1: b = ((smp ^ k) & 1) != 0;
        2: b = ((smp >> (k % FRAME_NBIT)) & 1) != 0;
`ifdef SYNC_PATTERN_GEN_PRBS_EN
        default: b = ((m_lfsr[k] >> 14) & 1) != 0;
`else
        default: b = 1'b0;
`endif
      endcase
      e_data[k] = active && b;
    end

    if (active) begin
      m_pos = frame_end ? 0 : m_pos + 1;
      if (frame_end) m_fcnt = (m_fcnt + 1) % (1 << FCNT_NBIT);
      if (div_end)
        for (int k = 0; k < NCHN; k++)
          m_lfsr[k] = ((m_lfsr[k] << 1) | (((m_lfsr[k] >> 14) ^ (m_lfsr[k] >> 13)) & 1)) & 32'h7FFF;
    end

    case (m_state)
      0: if (en) begin
           model_load();
           m_pos = 0; m_fcnt = 0; m_state = 1;
           for (int k = 0; k < NCHN; k++) m_lfsr[k] = 32'h7FFF ^ k;
         end
      1: begin
           if (frame_end) model_load();
           if (!en) m_state = 2;
         end
      default: begin
           if (frame_end) m_state = 0;
           else if (en)   m_state = 1;
         end
    endcase
    e_fcnt = FCNT_NBIT'(m_fcnt);
  endtask

  task automatic check(input string tag);
    logic [22:0] obs, exp;
    obs = {out_sync, out_spclk, out_data, sample_stb, frame_stb, busy, frame_cnt};
    exp = {e_sync, e_spclk, e_data, e_sstb, e_fstb, e_busy, e_fcnt};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s vec %0d {sync,spclk,data,sstb,fstb,busy,fcnt}: observed %b expected %b",
             tag, n_vec, obs, exp);
    end
  endtask

  // Called just after a rising edge: inputs set before this hold across the next edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge mclk);
    #1;
    check(tag);
  endtask

  task automatic direct(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic prev_fstb;
    model_reset();
    @(posedge mclk);
    #1;
    check("reset");
    rst_n = 1'b1;
    tick("idle");

    // Short frame, en dropped during sample 1: the frame must still complete.
    div_max = 9'd3; frame_len = 10'd3; spclk_high = 9'd2; sync_len = 10'd1;
    data_split = 10'd2; mode = 2'd0; en = 1'b1;
    for (int i = 0; i < 6; i++) tick("stop_run");
    en = 1'b0;
    prev_fstb = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
      prev_fstb = frame_stb;
      tick("stop_drain");
    end
    direct("stop_busy_low", 32'(busy), 32'd0);
    direct("stop_fstb_before_idle", 32'(prev_fstb), 32'd1);
    direct("stop_frame_cnt", 32'(frame_cnt), 32'd1);
    direct("stop_outputs_zero", 32'({out_sync, out_spclk, out_data, sample_stb, frame_stb}), 32'd0);

    // div_max change in mid-frame takes effect at the next frame.
    div_max = 9'd3; frame_len = 10'd2; sync_len = 10'd2; en = 1'b1;
    for (int i = 0; i < 5; i++) tick("period_old");
    div_max = 9'd7; spclk_high = 9'd4;
    for (int i = 0; i < 60; i++) tick("period_new");

    // div_max 0 behaves as 1, single-sample frames, sync constant high.
    div_max = 9'd0; frame_len = 10'd0; sync_len = 10'd1; spclk_high = 9'd1;
    for (int i = 0; i < 40; i++) tick("clamp");

    // Data modes on two channels.
    div_max = 9'd2; frame_len = 10'd5; sync_len = 10'd7; data_split = 10'd3;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      for (int i = 0; i < 50; i++) tick("modes");
    end

    // Randomised run: config and en changes at arbitrary points.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) begin
        div_max    = 9'($urandom_range(0, 5));
        spclk_high = 9'($urandom_range(0, 7));
        frame_len  = 10'($urandom_range(0, 4));
        sync_len   = 10'($urandom_range(0, 6));
        data_split = 10'($urandom_range(0, 6));
        mode       = 2'($urandom_range(0, 3));
      end
      tick("random");
    end

    // Asynchronous reset between clock edges while running.
    en = 1'b1;
    for (int i = 0; i < 20; i++) tick("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge mclk);
    #1;
    check("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) begin
        div_max   = 9'($urandom_range(0, 4));
        frame_len = 10'($urandom_range(0, 3));
        mode      = 2'($urandom_range(0, 3));
      end
      tick("post_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
